// File: rtl/alternating_counter_checker.sv
// Receive-side monitor for an alternating-counter pair. It checks the A/B step
// protocol, reports lock status, strobes each violation and keeps a saturating error count.
module alternating_counter_checker #(
  parameter int WIDTH      = 8,
  parameter int STEP_A     = 1,
  parameter int STEP_B     = 1,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             latch,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             locked,
  output logic             err_pulse,
  output logic [7:0]       err_count,
  output logic             phase
);

  typedef enum logic [1:0] {
    SYNC0 = 2'd0,
    SYNC1 = 2'd1,
    TRACK = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] STEP_A_W = WIDTH'(STEP_A);
  localparam logic [WIDTH-1:0] STEP_B_W = WIDTH'(STEP_B);
  localparam logic [3:0]       LOCK_W   = 4'(LOCK_COUNT);

  state_t           state_r, state_s;
  logic [WIDTH-1:0] prev_a_r, prev_b_r;
  logic [3:0]       good_r, good_s;
  logic             phase_s, locked_s, pulse_s;
  logic [7:0]       count_s;
  logic             a_step_s, b_step_s, hold_s, expected_s;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'd255) ? 8'd255 : v + 8'd1;
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'd15) ? 4'd15 : v + 4'd1;
  endfunction

  // Classify the current sample against the previous one (modulo 2^WIDTH).
  always_comb begin
    hold_s     = (in_a == prev_a_r) && (in_b == prev_b_r);
    a_step_s   = (in_a == prev_a_r + STEP_A_W) && (in_b == prev_b_r);
    b_step_s   = (in_b == prev_b_r + STEP_B_W) && (in_a == prev_a_r);
    expected_s = phase ? b_step_s : a_step_s;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s = state_r;
    good_s  = good_r;
    phase_s = phase;
    pulse_s = 1'b0;
    count_s = err_count;
    case (state_r)
      SYNC0: begin
        state_s = SYNC1;
      end
      SYNC1: begin
        if (latch && a_step_s) begin
          state_s = TRACK;
          phase_s = 1'b1;
          good_s  = 4'd1;
        end else if (latch && b_step_s) begin
          state_s = TRACK;
          phase_s = 1'b0;
          good_s  = 4'd1;
        end else begin
          state_s = SYNC1;
        end
      end
      TRACK: begin
        if (!latch && hold_s) begin
          state_s = TRACK;
        end else if (latch && expected_s) begin
          phase_s = ~phase;
          good_s  = sat_inc4(good_r);
        end else begin
          // Any other sample is a violation; it becomes the new reference.
          state_s = SYNC1;
          good_s  = 4'd0;
          pulse_s = 1'b1;
          count_s = sat_inc8(err_count);
        end
      end
      default: begin
        state_s = SYNC0;
        good_s  = 4'd0;
      end
    endcase
    locked_s = (state_s == TRACK) && (good_s >= LOCK_W);
  end

  // State, sample history and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r   <= SYNC0;
      prev_a_r  <= '0;
      prev_b_r  <= '0;
      good_r    <= 4'd0;
      phase     <= 1'b0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= 8'd0;
    end else begin
      state_r   <= state_s;
      prev_a_r  <= in_a;
      prev_b_r  <= in_b;
      good_r    <= good_s;
      phase     <= phase_s;
      locked    <= locked_s;
      err_pulse <= pulse_s;
      err_count <= count_s;
    end
  end

endmodule

// File: tb/tb_alternating_counter_checker.sv
// Randomised self-checking bench for alternating_counter_checker against a
// sample-difference reference model.
module tb_alternating_counter_checker;

  logic       clock, reset, latch;
  logic [7:0] in_a, in_b;
  logic       locked, err_pulse, phase;
  logic [7:0] err_count;

  int passes = 0;
  int checks = 0;

  // Reference model: mode 0 = no reference, 1 = reference only, 2 = tracking
  int         m_mode, m_good, m_cnt;
  logic [7:0] m_pa, m_pb;
  logic       m_phase, m_pulse, m_locked;
  logic [7:0] ta, tb;

  alternating_counter_checker #(.WIDTH(8), .STEP_A(1), .STEP_B(1), .LOCK_COUNT(4)) dut (
    .clock(clock), .reset(reset), .latch(latch), .in_a(in_a), .in_b(in_b),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .phase(phase)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_reset();
    m_mode = 0; m_good = 0; m_cnt = 0; m_pa = 8'd0; m_pb = 8'd0;
    m_phase = 1'b0; m_pulse = 1'b0; m_locked = 1'b0;
  endtask

  task automatic model_step(input logic l, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] da, db;
    bit a_ok, b_ok, still, want;
    da = a - m_pa;
    db = b - m_pb;
    still = (da == 8'd0) && (db == 8'd0);
    a_ok = (da == 8'd1) && (db == 8'd0);
    b_ok = (db == 8'd1) && (da == 8'd0);
    m_pulse = 1'b0;
    if (m_mode == 0) m_mode = 1;
    else if (m_mode == 1) begin
      if (l && (a_ok || b_ok)) begin
        m_mode = 2; m_good = 1; m_phase = a_ok;
      end
    end else begin
      want = m_phase ? b_ok : a_ok;
      if (!l && still) begin
      end else if (l && want) begin
        m_phase = !m_phase;
        if (m_good < 15) m_good++;
      end else begin
        m_pulse = 1'b1; m_good = 0; m_mode = 1;
        if (m_cnt < 255) m_cnt++;
      end
    end
    m_pa = a; m_pb = b;
    m_locked = (m_mode == 2) && (m_good >= 4);
  endtask

  task automatic tick(input logic l, input logic [7:0] a, input logic [7:0] b);
    @(negedge clock);
    latch = l; in_a = a; in_b = b;
    @(posedge clock);
    model_step(l, a, b);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; latch = 1'b0; in_a = 8'd0; in_b = 8'd0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      latch = 1'($urandom); in_a = 8'($urandom); in_b = 8'($urandom);
      @(posedge clock); #1;
      checks++;
      if ({locked, err_pulse, err_count, phase} !== 11'd0)
        $display("FAIL reset: got locked=%b pulse=%b count=%0d phase=%b, want all 0", locked, err_pulse, err_count, phase);
      else passes++;
    end
    @(negedge clock);
    reset = 1'b1;
    ta = 8'd0; tb = 8'd0;
  endtask

  task automatic test_clean_lock();
    logic [7:0] sa [5] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd2};
    logic [7:0] sb [5] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2};
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, sa[i], sb[i]);
      checks++;
      if (locked !== m_locked || err_pulse !== 1'b0 || err_count !== 8'd0)
        $display("FAIL clean_lock[%0d]: locked=%b pulse=%b count=%0d, want locked=%b pulse=0 count=0", i, locked, err_pulse, err_count, m_locked);
      else passes++;
    end
    checks++;
    if (locked !== 1'b1 || phase !== 1'b0)
      $display("FAIL clean_lock_final: locked=%b phase=%b, want locked=1 phase=0", locked, phase);
    else passes++;
    ta = 8'd2; tb = 8'd2;
  endtask

  task automatic test_wrap();
    int bad = 0;
    for (int i = 0; i < 520; i++) begin
      if (m_phase) tb = tb + 8'd1; else ta = ta + 8'd1;
      tick(1'b1, ta, tb);
      if (locked !== 1'b1 || err_pulse !== 1'b0 || phase !== m_phase) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL wrap: %0d cycles lost lock/pulsed/wrong phase, want 0", bad);
    else passes++;
  endtask

  task automatic test_pause();
    logic saved;
    int bad = 0;
    saved = phase;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, ta, tb);
      if (err_pulse !== 1'b0 || phase !== saved || locked !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL pause_hold: %0d bad cycles, want 0", bad);
    else passes++;
    ta = ta + 8'd1;
    tick(1'b0, ta, tb);
    checks++;
    if (err_pulse !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0)
      $display("FAIL pause_move: pulse=%b count=%0d locked=%b, want 1/1/0", err_pulse, err_count, locked);
    else passes++;
    tick(1'b0, ta, tb);
    checks++;
    if (err_pulse !== 1'b0) $display("FAIL pause_pulse_width: pulse=%b, want 0", err_pulse);
    else passes++;
  endtask

  task automatic test_wrong_phase();
    int n = 0;
    while (!(m_locked && !m_phase) && n < 20) begin
      if (m_mode == 2 && m_phase) tb = tb + 8'd1; else ta = ta + 8'd1;
      tick(1'b1, ta, tb);
      n++;
    end
    checks++;
    if (locked !== 1'b1 || phase !== 1'b0 || n >= 20)
      $display("FAIL wrong_phase_setup: locked=%b phase=%b after %0d steps, want 1/0", locked, phase, n);
    else passes++;
    tb = tb + 8'd1;
    tick(1'b1, ta, tb);
    checks++;
    if (err_pulse !== 1'b1 || err_count !== 8'(m_cnt) || locked !== 1'b0)
      $display("FAIL wrong_phase_err: pulse=%b count=%0d locked=%b, want 1/%0d/0", err_pulse, err_count, locked, m_cnt);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) ta = ta + 8'd1; else tb = tb + 8'd1;
      tick(1'b1, ta, tb);
      checks++;
      if (locked !== (i == 3) || err_pulse !== 1'b0)
        $display("FAIL relock[%0d]: locked=%b pulse=%b, want %b/0", i, locked, err_pulse, (i == 3));
      else passes++;
    end
  endtask

  task automatic test_random();
    int bad = 0;
    logic l;
    for (int i = 0; i < 400; i++) begin
      l = ($urandom_range(0, 4) != 0);
      case ($urandom_range(0, 4))
        0: ;
        1, 2: if (m_phase) tb = tb + 8'd1; else ta = ta + 8'd1;
        3: if (m_phase) ta = ta + 8'd1; else tb = tb + 8'd1;
        default: begin ta = 8'($urandom); tb = 8'($urandom); end
      endcase
      tick(l, ta, tb);
      if (locked !== m_locked || err_pulse !== m_pulse || err_count !== 8'(m_cnt) ||
          (m_locked && phase !== m_phase)) begin
        bad++;
        if (bad < 5)
          $display("FAIL random[%0d]: locked=%b pulse=%b count=%0d phase=%b, want %b/%b/%0d/%b",
                   i, locked, err_pulse, err_count, phase, m_locked, m_pulse, m_cnt, m_phase);
      end
    end
    checks++;
    if (bad == 0) passes++;
  endtask

  task automatic test_saturation();
    int bad = 0;
    for (int i = 0; i < 260; i++) begin
      ta = ta + 8'd1;
      tick(1'b1, ta, tb);
      ta = ta + 8'd5; tb = tb + 8'd3;
      tick(1'b1, ta, tb);
      if (err_count !== 8'(m_cnt) || err_pulse !== m_pulse) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL saturation_track: %0d cycles disagreed with model", bad);
    else passes++;
    checks++;
    if (err_count !== 8'd255) $display("FAIL saturation: count=%0d, want 255", err_count);
    else passes++;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if (err_count !== 8'd0 || locked !== 1'b0 || err_pulse !== 1'b0)
      $display("FAIL async_reset: count=%0d locked=%b pulse=%b, want 0/0/0", err_count, locked, err_pulse);
    else passes++;
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_wrap();
    test_pause();
    test_wrong_phase();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
